vsw_sequencer: RTL and testbench
================================

# vsw_sequencer

Sequencer for vector store (vector SW). It steps the register file's `cnt` element index so that read port 2 returns the elements of one vector register one per element. Each element is written to data memory at consecutive word addresses, under a ready/valid handshake with backpressure. It sits between the decode/execute stage and the data memory port, stalls the scalar pipeline while active, and pulses `done` when the last element is accepted.

## Interface
Parameters:
- `VLEN_MAX`, default 8: maximum number of elements per vector register; the effective length is clamped to this.
- `AW`, default 32: data memory address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  single-cycle request to begin a vector store; ignored while `busy`.
- `vs_base`  in  5  GPR index of element 0 of the source vector (8, 16 or 24).
- `mem_base`  in  AW  byte address for element 0.
- `vlen`  in  32  vector length from the register file's `vlen` output; sampled on `start`.
- `rf_rdata`  in  32  register file `read_data2`; registered read, valid one cycle after `cnt`/`rf_raddr2`.
- `dm_ready`  in  1  memory accepts the write this cycle.
- `rf_raddr2`  out  5  register file `read_addr2`; holds latched `vs_base` while busy, else 0.
- `cnt`  out  5  register file `cnt`; 0 when idle, otherwise the 1-based element index e.
- `dm_we`  out  1  write valid.
- `dm_addr`  out  AW  `mem_base + 4*(e-1)`, modulo 2^AW.
- `dm_wdata`  out  32  equals `rf_rdata` during WRITE.
- `stall`  out  1  `start | busy`; freezes upstream pipeline.
- `busy`  out  1  registered; high in FETCH, WRITE and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `err`  out  1  one-cycle pulse; present only with `VSW_ALIGN_CHECK_EN`, otherwise tied 0.

## Operation
- State machine with states IDLE, FETCH, WRITE and DONE.
- IDLE, on `start`:
  - latch `vs_base` and `mem_base`;
  - latch n = min(`vlen`, `VLEN_MAX`); comparison is unsigned 32-bit;
  - set e = 1;
  - go to FETCH if n > 0, else go to DONE.
- FETCH:
  - `cnt` = e, `dm_we` = 0;
  - always go to WRITE next cycle.
- WRITE:
  - `cnt` holds e, so `rf_rdata` stays stable across stalls;
  - `dm_we` = 1;
  - if `dm_ready` and e == n: go to DONE;
  - if `dm_ready` and e < n: e++, go to FETCH;
  - if not `dm_ready`: stay, with all outputs held.
- DONE:
  - `done` = 1, `cnt` = 0;
  - go to IDLE.
- A `start` arriving in any non-IDLE state is dropped; no queueing.
- The sequencer never drives register file write ports. The pipeline must not assert `write` or `VRegWrite` while `stall` is high.

## Timing
- Reset values, all outputs and state:
  - state IDLE, e = 0;
  - `cnt`, `dm_we`, `busy`, `done`, `err` = 0;
  - `rf_raddr2` = 0, `dm_addr` = 0.
- `dm_wdata` is combinational from `rf_rdata`.
- `rst_n` low mid-operation aborts the store on the next edge. No further `dm_we`, and no `done`.
- With `start` at cycle 0 and no backpressure:
  - FETCH e at cycle 2e-1;
  - WRITE e at cycle 2e;
  - `done` at cycle 2n+1;
  - `busy` low and a new `start` accepted at cycle 2n+2.
- Each cycle `dm_ready` is low in WRITE adds exactly one cycle.
- With n = 0: `done` at cycle 1, no `dm_we`.
- Address wrap past 2^AW-1 wraps silently.

## Configuration
- `VSW_ALIGN_CHECK_EN` defined:
  - on `start` with `mem_base[1:0]` != 0, go to DONE with no writes;
  - `err` and `done` both pulse in that DONE cycle.
- Not defined: no alignment check; `err` is constant 0, and the low address bits pass through unchanged.

## Test plan
- Store v1 (`vs_base`=16), `vlen`=3, `mem_base`=0x100, `dm_ready`=1, v1 = {A,B,C}:
  - writes (0x100,A), (0x104,B), (0x108,C) at cycles 2, 4, 6;
  - `cnt` sequence 1,1,2,2,3,3;
  - `done` at cycle 7.
- `vlen`=20, v0 = 8 elements: exactly 8 writes to 0x0..0x1C; `done` at cycle 17.
- `vlen`=0: `done` at cycle 1, no `dm_we`, `busy` high for exactly one cycle.
- `dm_ready` low for 3 cycles on element 2: `dm_we`, `dm_addr`, `dm_wdata` and `cnt`=2 held stable; `done` delayed by 3 cycles.
- `start` repeated during busy, then `rst_n` low at cycle 3:
  - the second `start` is ignored;
  - after reset, all outputs are 0 and no `done` occurs.
- With `VSW_ALIGN_CHECK_EN`, `mem_base`=0x102: `err`=`done`=1 at cycle 1, no writes.

Source files
------------

// File: rtl/vsw_sequencer.sv
// Vector store sequencer: walks one vector register element by element and writes it to data memory.
// Optional `VSW_ALIGN_CHECK_EN rejects misaligned base addresses with an err pulse.
module vsw_sequencer #(
  parameter int VLEN_MAX = 8,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [4:0]    vs_base,
  input  logic [AW-1:0] mem_base,
  input  logic [31:0]   vlen,
  input  logic [31:0]   rf_rdata,
  input  logic          dm_ready,
  output logic [4:0]    rf_raddr2,
  output logic [4:0]    cnt,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  output logic          stall,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  localparam logic [31:0] VMAX = 32'(VLEN_MAX);

  state_t        state_q, state_d;
  logic [4:0]    vs_base_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   n_q, e_q;
  logic [31:0]   n_in;
  logic          load, advance;
  logic          misaligned;

  assign n_in = (vlen > VMAX) ? VMAX : vlen;

`ifdef VSW_ALIGN_CHECK_EN
  logic err_q;
  assign misaligned = (mem_base[1:0] != 2'b00);
  assign err        = (state_q == DONE) && err_q;
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign stall     = start | busy;
  assign rf_raddr2 = busy ? vs_base_q : 5'd0;
  assign dm_wdata  = rf_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vs_base_q <= '0;
      addr_q    <= '0;
      n_q       <= '0;
      e_q       <= '0;
`ifdef VSW_ALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        vs_base_q <= vs_base;
        addr_q    <= mem_base;
        n_q       <= n_in;
        e_q       <= 32'd1;
`ifdef VSW_ALIGN_CHECK_EN
        err_q     <= misaligned;
`endif
      end else if (advance) begin
        e_q    <= e_q + 32'd1;
        addr_q <= addr_q + AW'(4);
      end
    end
  end

  // cnt and dm_addr stay frozen through WRITE so the registered read data holds under backpressure
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    cnt     = 5'd0;
    dm_we   = 1'b0;
    dm_addr = '0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (misaligned || n_in == 32'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        cnt     = e_q[4:0];
        dm_addr = addr_q;
        state_d = WRITE;
      end
      WRITE: begin
        cnt     = e_q[4:0];
        dm_addr = addr_q;
        dm_we   = 1'b1;
        if (dm_ready) begin
          if (e_q == n_q) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vsw_sequencer.sv
// Scoreboard bench for vsw_sequencer: expected writes are queued at start and popped on accepted writes.
// A small register file model returns a recognisable value per (vs_base, element).
module tb_vsw_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  vs_base = 5'd0;
  logic [31:0] mem_base = 32'd0;
  logic [31:0] vlen = 32'd0;
  logic [31:0] rf_rdata = 32'd0;
  logic        dm_ready = 1'b1;
  logic [4:0]  rf_raddr2;
  logic [4:0]  cnt;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        stall;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  idx;
    logic [4:0]  base;
    int          cyc;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  exp_done = -1;
  int  exp_busy = 0;
  int  busy_cnt = 0;
  int  stall_elem = 0;
  int  stall_left = 0;
  logic exp_err = 1'b0;
  logic done_seen = 1'b0;

  vsw_sequencer #(.VLEN_MAX(8), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vs_base(vs_base), .mem_base(mem_base),
    .vlen(vlen), .rf_rdata(rf_rdata), .dm_ready(dm_ready), .rf_raddr2(rf_raddr2),
    .cnt(cnt), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .stall(stall),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] elem_val(input logic [4:0] base, input logic [4:0] idx);
    return {8'hA5, 3'b000, base, 8'h3C, 3'b000, idx};
  endfunction

  // Registered read port: data for (read_addr2, cnt) appears one cycle later
  always @(posedge clk) rf_rdata <= elem_val(rf_raddr2, cnt);

  always @(posedge clk) begin
    #1;
    if (dm_we && cnt == 5'(stall_elem) && stall_left > 0) begin
      dm_ready = 1'b0;
      stall_left--;
    end else begin
      dm_ready = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (dm_we) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          checkOutput("dm_addr", dm_addr, q[0].addr);
          checkOutput("dm_wdata", dm_wdata, q[0].data);
          checkOutput("cnt_write", cnt, q[0].idx);
          checkOutput("rf_raddr2", rf_raddr2, q[0].base);
          if (dm_ready) begin
            checkOutput("write_cycle", cyc - t0, q[0].cyc);
            void'(q.pop_front());
          end
        end
      end
      if (done) begin
        done_seen = 1'b1;
        if (exp_done < 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          checkOutput("done_cycle", cyc - t0, exp_done);
          checkOutput("err_in_done", err, exp_err);
          checkOutput("cnt_in_done", cnt, 0);
        end
      end else if (err) begin
        checkOutput("stray_err", 1, 0);
      end
    end
  end

  task automatic waitDone();
    int k = 0;
    while (!done_seen && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    checkOutput("done_seen", done_seen, 1);
    checkOutput("busy_after", busy, 0);
    checkOutput("busy_cycles", busy_cnt, exp_busy);
    checkOutput("pending_writes", q.size(), 0);
    q.delete();
  endtask

  // Called at posedge+1: the current cycle becomes cycle 0 of the store
  task automatic applyStimulus(input logic [4:0] base, input logic [31:0] mbase,
                               input logic [31:0] len, input int se, input int sc);
    logic [31:0] n;
    logic        mis;
    int          s;
    n   = (len > 32'd8) ? 32'd8 : len;
    mis = 1'b0;
`ifdef VSW_ALIGN_CHECK_EN
    mis = (mbase[1:0] != 2'b00);
`endif
    if (mis) n = 32'd0;
    s = (se >= 1 && se <= int'(n)) ? sc : 0;
    for (int e = 1; e <= int'(n); e++) begin
      q.push_back('{addr: mbase + 32'(4 * (e - 1)), data: elem_val(base, 5'(e)),
                    idx: 5'(e), base: base, cyc: 2 * e + ((se > 0 && e >= se) ? sc : 0)});
    end
    exp_done   = 2 * int'(n) + 1 + s;
    exp_busy   = exp_done;
    exp_err    = mis;
    done_seen  = 1'b0;
    busy_cnt   = 0;
    stall_elem = se;
    stall_left = sc;
    t0         = cyc;
    start      = 1'b1;
    vs_base    = base;
    mem_base   = mbase;
    vlen       = len;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_cnt", cnt, 0);
    checkOutput("reset_dm_we", dm_we, 0);
    checkOutput("reset_dm_addr", dm_addr, 0);
    checkOutput("reset_raddr2", rf_raddr2, 0);
    checkOutput("reset_done_err", {done, err}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(5'd16, 32'h0000_0100, 32'd3, 0, 0);
    applyStimulus(5'd8, 32'h0000_0000, 32'd20, 0, 0);
    applyStimulus(5'd8, 32'h0000_0040, 32'd0, 0, 0);
    applyStimulus(5'd24, 32'h0000_0200, 32'd4, 2, 3);
    applyStimulus(5'd16, 32'hFFFF_FFF8, 32'd4, 0, 0);
    applyStimulus(5'd8, 32'h0000_0102, 32'd2, 0, 0);
    applyStimulus(5'd24, 32'h0000_1000, 32'hFFFF_FFFF, 5, 1);

    // Repeated start while busy, then reset in the middle of the store
    exp_done  = -1;
    done_seen = 1'b0;
    t0        = cyc;
    q.push_back('{addr: 32'h300, data: elem_val(5'd8, 5'd1), idx: 5'd1, base: 5'd8, cyc: 2});
    start = 1'b1; vs_base = 5'd8; mem_base = 32'h300; vlen = 32'd5;
    @(posedge clk); #1;
    start = 1'b1; vs_base = 5'd16; mem_base = 32'h400; vlen = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_dm_we", dm_we, 0);
    checkOutput("abort_cnt", cnt, 0);
    checkOutput("abort_dm_addr", dm_addr, 0);
    checkOutput("abort_raddr2", rf_raddr2, 0);
    checkOutput("abort_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_pending", q.size(), 0);
    checkOutput("abort_no_done", done_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
